fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Owns the PC register, drives the instruction-memory request, and produces the IF/ID pipeline latch (`IF_ID_t`) consumed by the decode stage. It redirects on a resolved branch/jump from EX/MEM and honours hazard-unit stalls and the committed halt. It optionally adds a small branch target buffer (BTB) for next-PC prediction.

---
 rtl/dp_types_pkg.sv | 35 +++
 rtl/fetch_btb.sv | 85 ++++++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_types_pkg.sv
// ---------------------------------------------------------------------------
// dp_types_pkg
//   Shared datapath types for the five-stage pipeline.
//   - IF_ID_t     : IF/ID pipeline latch {imemload, pc, pc4, npc}
//   - btb_entry_t : one branch-target-buffer entry (valid, tag, target)
//   - BTB_IDX_W   : index width for the default BTB depth
//   The tag field is sized for the narrowest possible index so that any
//   power-of-two BTB depth can store its tag zero-extended in the same type.
// ---------------------------------------------------------------------------
package dp_types_pkg;

  typedef struct packed {
    logic [31:0] imemload;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] npc;
  } IF_ID_t;

  localparam int BTB_DEFAULT_ENTRIES = 4;
  localparam int BTB_IDX_W           = $clog2(BTB_DEFAULT_ENTRIES);
  // Word-aligned PCs leave 30 meaningful bits; the tag never exceeds that.
  localparam int BTB_TAG_MAX_W       = 30;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
  } btb_entry_t;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// ---------------------------------------------------------------------------
// fetch_btb
//   Direct-mapped branch target buffer used by fetch_stage when the
//   FETCH_BTB_EN macro is defined.
//   Ports:
//     CLK, nRST      clock, asynchronous active-low reset (clears valid bits)
//     i_lookup_pc    PC being fetched this cycle
//     o_hit          entry valid and tag matches i_lookup_pc
//     o_target       predicted target of the matching entry
//     i_wen          update strobe (already gated by the halt state)
//     i_wr_pc        PC of the resolved control instruction
//     i_wr_target    resolved target
//     i_wr_taken     resolved outcome; not-taken invalidates the entry
//   Lookup is combinational from registered storage, so a same-cycle update
//   to the same index is only seen on the following cycle.
// ---------------------------------------------------------------------------
module fetch_btb
  import dp_types_pkg::*;
#(
  parameter int ENTRIES = BTB_DEFAULT_ENTRIES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] i_lookup_pc,
  output logic        o_hit,
  output logic [31:0] o_target,
  input  logic        i_wen,
  input  logic [31:0] i_wr_pc,
  input  logic [31:0] i_wr_target,
  input  logic        i_wr_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic                     r_valid  [ENTRIES];
  logic [BTB_TAG_MAX_W-1:0] r_tag    [ENTRIES];
  logic [31:0]              r_target [ENTRIES];

  logic [IDX_W-1:0]         w_lu_idx;
  logic [BTB_TAG_MAX_W-1:0] w_lu_tag;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [BTB_TAG_MAX_W-1:0] w_wr_tag;
  btb_entry_t               w_lu_entry;
  btb_entry_t               w_wr_entry;
  logic                     w_unused_lsb;

  assign w_lu_idx = i_lookup_pc[2 +: IDX_W];
  assign w_wr_idx = i_wr_pc[2 +: IDX_W];
  // Tag is PC[31:2+IDX_W], zero-extended into the fixed-width tag field.
  assign w_lu_tag = BTB_TAG_MAX_W'(i_lookup_pc >> (2 + IDX_W));
  assign w_wr_tag = BTB_TAG_MAX_W'(i_wr_pc >> (2 + IDX_W));

  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused_lsb = ^{i_lookup_pc[1:0], i_wr_pc[1:0]};

  assign w_lu_entry = '{valid:  r_valid[w_lu_idx],
                        tag:    r_tag[w_lu_idx],
                        target: r_target[w_lu_idx]};

  assign w_wr_entry = '{valid:  i_wr_taken,
                        tag:    w_wr_tag,
                        target: i_wr_target};

  assign o_hit    = w_lu_entry.valid && (w_lu_entry.tag == w_lu_tag);
  assign o_target = w_lu_entry.target;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (i_wen) begin
      r_valid[w_wr_idx] <= w_wr_entry.valid;
    end
  end

  // Tag/target need no reset: they are qualified by the valid bit.
  always_ff @(posedge CLK) begin
    if (i_wen) begin
      r_tag[w_wr_idx]    <= w_wr_entry.tag;
      r_target[w_wr_idx] <= w_wr_entry.target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: owns the PC, issues the instruction-memory
//   request and produces the IF/ID latch for decode.
//   Optional feature macro: FETCH_BTB_EN (adds fetch_btb next-PC prediction).
//   Ports:
//     CLK, nRST                clock, asynchronous active-low reset
//     ihit, imemload           instruction memory response
//     imemREN, imemaddr        instruction memory request (addr == PC)
//     stall                    hold PC and IF/ID
//     flush, redirect_pc       redirect from EX/MEM; clears IF/ID
//     halt                     committed halt; freezes the stage until reset
//     btb_wen/pc/target/taken  BTB update (ignored without FETCH_BTB_EN)
//     ifid, ifid_valid         IF/ID latch and its valid flag
//   Priority each cycle: halted > flush > stall > ihit > miss (bubble).
// ---------------------------------------------------------------------------
module fetch_stage
  import dp_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        btb_wen,
  input  logic [31:0] btb_pc,
  input  logic [31:0] btb_target,
  input  logic        btb_taken,
  output IF_ID_t      ifid,
  output logic        ifid_valid
);

  logic [31:0] r_pc;
  logic        r_halted;
  IF_ID_t      r_ifid;
  logic        r_ifid_valid;

  logic [31:0] w_pc4;
  logic [31:0] w_npc;
  logic        w_halted;

  // The halt cycle itself already behaves as halted, so halt beats a
  // same-cycle flush and no redirect or BTB update slips through.
  assign w_halted = r_halted | halt;
  assign w_pc4    = pc_plus4(r_pc);

`ifdef FETCH_BTB_EN
  logic        w_btb_hit;
  logic [31:0] w_btb_target;

  fetch_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_lookup_pc (r_pc),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_wen       (btb_wen & ~w_halted),
    .i_wr_pc     (btb_pc),
    .i_wr_target (btb_target),
    .i_wr_taken  (btb_taken)
  );

  assign w_npc = w_btb_hit ? w_btb_target : w_pc4;
`else
  logic [31:0] w_unused_btb_cfg;
  logic        w_unused_btb;

  // BTB ports stay in the port list but carry no function in this build.
  assign w_unused_btb_cfg = 32'(BTB_ENTRIES);
  assign w_unused_btb     = ^{btb_wen, btb_pc, btb_target, btb_taken,
                              w_unused_btb_cfg};
  assign w_npc            = w_pc4;
`endif

  assign imemREN    = ~w_halted;
  assign imemaddr   = r_pc;
  assign ifid       = r_ifid;
  assign ifid_valid = r_ifid_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halted <= 1'b0;
    end else if (halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc         <= PC_INIT;
      r_ifid       <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!w_halted) begin
      if (flush) begin
        r_pc         <= redirect_pc;
        r_ifid       <= '0;
        r_ifid_valid <= 1'b0;
      end else if (stall) begin
        r_pc         <= r_pc;
        r_ifid       <= r_ifid;
        r_ifid_valid <= r_ifid_valid;
      end else if (ihit) begin
        r_pc         <= w_npc;
        r_ifid       <= '{imemload: imemload, pc: r_pc, pc4: w_pc4, npc: w_npc};
        r_ifid_valid <= 1'b1;
      end else begin
        // Miss: keep requesting the same PC and push a bubble downstream.
        r_ifid       <= '0;
        r_ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: directed scenarios with literal
//   expectations followed by randomized traffic compared every cycle against
//   a behavioural model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import dp_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        btb_wen;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        btb_taken;
  IF_ID_t      ifid;
  logic        ifid_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .PC_INIT     (32'h0000_0000),
    .BTB_ENTRIES (4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .btb_wen     (btb_wen),
    .btb_pc      (btb_pc),
    .btb_target  (btb_target),
    .btb_taken   (btb_taken),
    .ifid        (ifid),
    .ifid_valid  (ifid_valid)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_halted;
  logic [31:0] m_instr, m_ipc, m_ipc4, m_inpc;
  bit          m_valid;
  // BTB model: remembers the full resolved PC per slot; a hit is simply
  // "the same word address was last resolved taken into this slot".
  bit          b_v   [4];
  logic [31:0] b_pc  [4];
  logic [31:0] b_tgt [4];

  function automatic logic [31:0] model_npc(input logic [31:0] pc);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
`ifdef FETCH_BTB_EN
    begin
      int slot;
      slot = int'((pc / 4) % 4);
      if (b_v[slot] && (b_pc[slot] / 4) == (pc / 4)) nxt = b_tgt[slot];
    end
`endif
    return nxt;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 0; m_valid = 0;
    m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_inpc = 0;
    for (int i = 0; i < 4; i++) begin
      b_v[i] = 0; b_pc[i] = 0; b_tgt[i] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("imemREN",    32'(imemREN),    32'(!(m_halted || halt)));
    chk("imemaddr",   imemaddr,        m_pc);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    chk("ifid.instr", ifid.imemload,   m_instr);
    chk("ifid.pc",    ifid.pc,         m_ipc);
    chk("ifid.pc4",   ifid.pc4,        m_ipc4);
    chk("ifid.npc",   ifid.npc,        m_inpc);
  endtask

  task automatic idle_inputs();
    ihit = 0; imemload = 0; stall = 0; flush = 0; redirect_pc = 0;
    halt = 0; btb_wen = 0; btb_pc = 0; btb_target = 0; btb_taken = 0;
  endtask

  // Called one time unit after a rising edge.
  task automatic do_reset();
    nRST = 0;
    idle_inputs();
    #1;
    model_reset();
    check_all();
    $display("[TB] reset: imemaddr=%h imemREN=%0b ifid_valid=%0b", imemaddr, imemREN, ifid_valid);
    nRST = 1;
    #1;
  endtask

  // Drive one cycle of inputs, check current outputs, advance model at edge.
  task automatic step(input bit i_hit, input bit i_stall, input bit i_flush,
                      input logic [31:0] rpc, input bit i_halt,
                      input bit wen, input logic [31:0] bpc,
                      input logic [31:0] btgt, input bit btk,
                      input logic [31:0] word);
    bit          eh;
    logic [31:0] npc;
    logic [31:0] n_pc, n_instr, n_ipc, n_ipc4, n_inpc;
    bit          n_valid;
    int          slot;
    ihit = i_hit; stall = i_stall; flush = i_flush; redirect_pc = rpc;
    halt = i_halt; btb_wen = wen; btb_pc = bpc; btb_target = btgt;
    btb_taken = btk; imemload = word;
    #1;
    check_all();

    eh = m_halted || i_halt;
    npc = model_npc(m_pc);
    n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_ipc4 = m_ipc4;
    n_inpc = m_inpc; n_valid = m_valid;
    if (!eh) begin
      if (i_flush) begin
        n_pc = rpc; n_valid = 0;
        n_instr = 0; n_ipc = 0; n_ipc4 = 0; n_inpc = 0;
      end else if (i_stall) begin
        // hold everything
      end else if (i_hit) begin
        n_pc = npc; n_valid = 1;
        n_instr = word; n_ipc = m_pc; n_ipc4 = m_pc + 32'd4; n_inpc = npc;
      end else begin
        n_valid = 0;
        n_instr = 0; n_ipc = 0; n_ipc4 = 0; n_inpc = 0;
      end
    end
    $display("[TB] pc=%h ihit=%0b stall=%0b flush=%0b halt=%0b wen=%0b -> pc'=%h valid'=%0b",
             m_pc, i_hit, i_stall, i_flush, i_halt, wen, n_pc, n_valid);

    @(posedge CLK);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_ipc4 = n_ipc4;
    m_inpc = n_inpc; m_valid = n_valid;
    if (i_halt) m_halted = 1;
    if (wen && !eh) begin
      slot = int'((bpc / 4) % 4);
      b_v[slot] = btk; b_pc[slot] = bpc; b_tgt[slot] = btgt;
    end
  endtask

  task automatic fetch(input logic [31:0] word);
    step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, word);
  endtask

  task automatic redirect(input logic [31:0] rpc);
    step(0, 0, 1, rpc, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  logic [31:0] frozen_addr;
  logic [31:0] frozen_pc;

  initial begin
    nRST = 0;
    idle_inputs();
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();
    chk("rst imemaddr", imemaddr, 32'h0);
    chk("rst imemREN", 32'(imemREN), 32'd1);
    chk("rst valid", 32'(ifid_valid), 32'd0);

    // Reset and stream
    fetch(32'hAAAA_0001);
    chk("s1 pc", ifid.pc, 32'h0);   chk("s1 npc", ifid.npc, 32'h4);
    fetch(32'hBBBB_0002);
    chk("s2 pc", ifid.pc, 32'h4);   chk("s2 npc", ifid.npc, 32'h8);
    fetch(32'hCCCC_0003);
    chk("s3 pc", ifid.pc, 32'h8);   chk("s3 npc", ifid.npc, 32'hC);
    chk("s3 instr", ifid.imemload, 32'hCCCC_0003);
    chk("s3 valid", 32'(ifid_valid), 32'd1);
    chk("s3 imemaddr", imemaddr, 32'hC);

    // Miss then stall
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
    chk("miss valid", 32'(ifid_valid), 32'd0);
    chk("miss imemaddr", imemaddr, 32'hC);
    fetch(32'h1111_2222);
    step(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h3333_4444);
    chk("stall pc", ifid.pc, 32'hC);
    chk("stall instr", ifid.imemload, 32'h1111_2222);
    chk("stall imemaddr", imemaddr, 32'h10);

    // Flush over stall
    step(1, 1, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h5555_6666);
    chk("flush imemaddr", imemaddr, 32'h40);
    chk("flush valid", 32'(ifid_valid), 32'd0);
    fetch(32'h7777_8888);
    chk("post flush pc", ifid.pc, 32'h40);

    // Wrap
    redirect(32'hFFFF_FFFC);
    fetch(32'h9999_0000);
    chk("wrap pc4", ifid.pc4, 32'h0);
    chk("wrap imemaddr", imemaddr, 32'h0);

`ifdef FETCH_BTB_EN
    step(1, 0, 0, 32'h0, 0, 1, 32'h10, 32'h100, 1, 32'h1234_0000);
    redirect(32'h10);
    fetch(32'hB0B0_0001);
    chk("btb hit npc", ifid.npc, 32'h100);
    chk("btb hit imemaddr", imemaddr, 32'h100);
    step(0, 0, 1, 32'h10, 0, 1, 32'h10, 32'h100, 0, 32'h0);
    fetch(32'hB0B0_0002);
    chk("btb nt npc", ifid.npc, 32'h14);
    step(0, 0, 1, 32'h20, 0, 1, 32'h10, 32'h100, 1, 32'h0);
    fetch(32'hB0B0_0003);
    chk("btb alias npc", ifid.npc, 32'h24);
    chk("btb alias imemaddr", imemaddr, 32'h24);
`endif

    // Halt, then a flush that must be ignored
    fetch(32'hABCD_0001);
    frozen_addr = imemaddr;
    frozen_pc   = ifid.pc;
    step(0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 32'h0);
    redirect(32'h80);
    chk("halt imemREN", 32'(imemREN), 32'd0);
    chk("halt imemaddr", imemaddr, frozen_addr);
    for (int i = 0; i < 4; i++) fetch($urandom);
    chk("halt ifid pc", ifid.pc, frozen_pc);
    chk("halt valid", 32'(ifid_valid), 32'd1);
    do_reset();
    chk("recover imemREN", 32'(imemREN), 32'd1);
    chk("recover imemaddr", imemaddr, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int r;
      logic [31:0] rpc;
      r = int'($urandom_range(0, 99));
      if (m_halted ? (r < 10) : (r < 1)) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0)
          rpc = 32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3);
        else
          rpc = 32'd4 * $urandom_range(0, 31);
        step($urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 1,
             rpc,
             $urandom_range(0, 99) < 1,
             $urandom_range(0, 3) == 0,
             32'd4 * $urandom_range(0, 31),
             32'd4 * $urandom_range(0, 63),
             $urandom_range(0, 9) < 7,
             $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
